refill_cache_dados: RTL and testbench

- Miss-handling controller that sits directly in front of cache_dados (16 lines, 32-byte blocks, direct-mapped).
- On a read miss it fetches the 8-word block from main memory over a req/ack handshake and assembles the 256-bit line.
- It then writes data, tag and valid into the cache in one cycle, which releases the pipeline stall.

---
 rtl/cache_pkg.sv | 40 ++++
 rtl/refill_cache_dados.sv | 132 +++++++++++++
 tb/tb_refill_cache_dados.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// cache_pkg
// Shared constants for the cache_dados data cache and its refill controller.
// Geometry: 16 direct-mapped lines of 32-byte blocks (8 x 32-bit words).
// Address layout: [31:9] tag, [8:5] line index, [4:0] byte offset in block.
// Also holds the refill FSM state encoding and two address-slicing helpers.
package cache_pkg;

    localparam int LINHAS         = 16;
    localparam int PALAVRAS_BLOCO = 8;
    localparam int BITS_INDEX     = 4;
    localparam int BITS_TAG       = 23;
    localparam int BITS_OFFSET    = 5;
    localparam int BITS_CONT      = 3;
    localparam int BITS_PALAVRA   = 32;
    localparam int BITS_LINHA     = PALAVRAS_BLOCO * BITS_PALAVRA;

    // Address-slicing positions, shared with cache_dados
    localparam int INDEX_LSB = BITS_OFFSET;
    localparam int INDEX_MSB = BITS_OFFSET + BITS_INDEX - 1;
    localparam int TAG_LSB   = BITS_OFFSET + BITS_INDEX;
    localparam int TAG_MSB   = 31;

    // Clears the byte offset, leaving the block base address
    localparam logic [31:0] BASE_MASK = ~((32'd1 << BITS_OFFSET) - 32'd1);

    // Refill FSM encoding
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] REQ  = 2'b01;
    localparam logic [1:0] FILL = 2'b10;
    localparam logic [1:0] DONE = 2'b11;

    function automatic logic [BITS_INDEX-1:0] addr_index(input logic [31:0] addr);
        return addr[INDEX_MSB:INDEX_LSB];
    endfunction

    function automatic logic [BITS_TAG-1:0] addr_tag(input logic [31:0] addr);
        return addr[TAG_MSB:TAG_LSB];
    endfunction

endpackage

// File: rtl/refill_cache_dados.sv
// refill_cache_dados
// Miss-handling controller in front of cache_dados. On a read miss it reads
// the 8 words of the block from main memory (req/ack handshake), assembles
// the 256-bit line and writes line, tag and valid into the cache with a
// single-cycle fill_we strobe.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-low reset
//   miss_req, miss_addr : miss indication and load address from the pipeline
//   mem_req, mem_addr   : word read request and word-aligned address to memory
//   mem_ack, mem_rdata  : request accepted, returned word valid in same cycle
//   fill_we             : one-cycle line write strobe to the cache
//   fill_index/tag/data : line index, tag and data for the write (held after)
//   busy                : controller is not idle
//   miss_count          : refills started, saturating at 16'hFFFF
module refill_cache_dados
    import cache_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    miss_req,
    input  logic [31:0]             miss_addr,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    input  logic                    mem_ack,
    input  logic [31:0]             mem_rdata,
    output logic                    fill_we,
    output logic [BITS_INDEX-1:0]   fill_index,
    output logic [BITS_TAG-1:0]     fill_tag,
    output logic [BITS_LINHA-1:0]   fill_data,
    output logic                    busy,
    output logic [15:0]             miss_count
);

    // The last word goes straight from mem_rdata into fill_data, so the
    // assembly register only needs the first seven words.
    localparam int BITS_ASM = (PALAVRAS_BLOCO - 1) * BITS_PALAVRA;

    logic [1:0]             state_q,      state_d;
    logic [BITS_CONT-1:0]   count_q,      count_d;
    logic [31:0]            base_q,       base_d;
    logic [BITS_ASM-1:0]    asm_q,        asm_d;
    logic [BITS_INDEX-1:0]  fill_index_q, fill_index_d;
    logic [BITS_TAG-1:0]    fill_tag_q,   fill_tag_d;
    logic [BITS_LINHA-1:0]  fill_data_q,  fill_data_d;
    logic [15:0]            miss_count_q, miss_count_d;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        base_d       = base_q;
        asm_d        = asm_q;
        fill_index_d = fill_index_q;
        fill_tag_d   = fill_tag_q;
        fill_data_d  = fill_data_q;
        miss_count_d = miss_count_q;

        case (state_q)
            IDLE: begin
                if (miss_req) begin
                    base_d  = miss_addr & BASE_MASK;
                    count_d = '0;
                    if (miss_count_q != 16'hFFFF) begin
                        miss_count_d = miss_count_q + 16'd1;
                    end
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    for (int k = 0; k < PALAVRAS_BLOCO - 1; k++) begin
                        if (count_q == BITS_CONT'(k)) begin
                            asm_d[BITS_PALAVRA*k +: BITS_PALAVRA] = mem_rdata;
                        end
                    end
                    // Fill outputs are only updated on the way into FILL so
                    // they keep the previous line during the next refill.
                    if (count_q == BITS_CONT'(PALAVRAS_BLOCO - 1)) begin
                        fill_data_d  = {mem_rdata, asm_q};
                        fill_index_d = addr_index(base_q);
                        fill_tag_d   = addr_tag(base_q);
                        state_d      = FILL;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            FILL: begin
                state_d = DONE;
            end
            DONE: begin
                // miss_req is stale here while the cache recomputes its hit
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            base_q       <= '0;
            asm_q        <= '0;
            fill_index_q <= '0;
            fill_tag_q   <= '0;
            fill_data_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            base_q       <= base_d;
            asm_q        <= asm_d;
            fill_index_q <= fill_index_d;
            fill_tag_q   <= fill_tag_d;
            fill_data_q  <= fill_data_d;
            miss_count_q <= miss_count_d;
        end
    end

    // base_q has a zero offset, so adding the word offset never carries
    assign mem_req    = (state_q == REQ);
    assign mem_addr   = (state_q == REQ) ? (base_q + 32'({count_q, 2'b00})) : 32'd0;
    assign fill_we    = (state_q == FILL);
    assign busy       = (state_q != IDLE);
    assign fill_index = fill_index_q;
    assign fill_tag   = fill_tag_q;
    assign fill_data  = fill_data_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_refill_cache_dados.sv
// tb_refill_cache_dados
// Self-checking bench for refill_cache_dados. A memory model answers word
// requests (always, every third cycle, or spuriously), the stimulus process
// pushes the expected fill for each miss into a queue, and a fill monitor
// pops and compares whenever fill_we is seen.
module tb_refill_cache_dados;

    logic           clock = 1'b0;
    logic           reset;
    logic           miss_req;
    logic [31:0]    miss_addr;
    logic           mem_req;
    logic [31:0]    mem_addr;
    logic           mem_ack;
    logic [31:0]    mem_rdata;
    logic           fill_we;
    logic [3:0]     fill_index;
    logic [22:0]    fill_tag;
    logic [255:0]   fill_data;
    logic           busy;
    logic [15:0]    miss_count;

    typedef struct {
        logic [3:0]   idx;
        logic [22:0]  tag;
        logic [255:0] data;
    } fill_t;

    int           checks = 0;
    int           errors = 0;
    int           fill_seen = 0;
    fill_t        exp_q[$];
    logic [31:0]  addr_log[$];
    int           ack_mode = 0;
    logic [31:0]  data_base = 32'd0;
    int           cycles;
    int           n;

    refill_cache_dados dut (
        .clock      (clock),
        .reset      (reset),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .fill_we    (fill_we),
        .fill_index (fill_index),
        .fill_tag   (fill_tag),
        .fill_data  (fill_data),
        .busy       (busy),
        .miss_count (miss_count)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] b);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = b + 32'(k);
        return r;
    endfunction

    task automatic checkAddrLog(input logic [31:0] base);
        checkOutput("addr_log_len", 256'(addr_log.size()), 256'd8);
        for (int k = 0; k < 8 && k < addr_log.size(); k++)
            checkOutput($sformatf("mem_addr_word%0d", k), addr_log[k], base + 32'(4*k));
    endtask

    // Issue one miss and count clock edges until busy drops again
    task automatic applyStimulus(input logic [31:0] addr, output int cyc);
        @(negedge clock);
        miss_req  = 1'b1;
        miss_addr = addr;
        @(posedge clock);
        cyc = 1;
        @(negedge clock);
        miss_req = 1'b0;
        while (busy && cyc < 200) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
        end
        if (cyc >= 200) checkOutput("refill_timeout", 256'(busy), 256'd0);
    endtask

    // Memory model: drives ack/data at the falling edge for the next rising edge
    initial begin
        int          wcnt;
        logic        waiting;
        logic        give;
        logic [31:0] held_addr;
        wcnt      = 0;
        waiting   = 1'b0;
        held_addr = 32'd0;
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEADBEEF;
        forever begin
            @(negedge clock);
            give      = 1'b0;
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEADBEEF;
            if (ack_mode == 1) begin
                give = mem_req;
            end else if (ack_mode == 2) begin
                if (mem_req) begin
                    if (waiting) checkOutput("addr_stable_wait", mem_addr, held_addr);
                    if (wcnt == 2) begin
                        give = 1'b1;
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    wcnt = 0;
                end
            end else if (ack_mode == 3) begin
                mem_ack = 1'b1;
            end
            if (give) begin
                mem_ack   = 1'b1;
                mem_rdata = data_base + 32'(mem_addr[4:2]);
                addr_log.push_back(mem_addr);
                waiting   = 1'b0;
            end else begin
                waiting   = mem_req;
                held_addr = mem_addr;
            end
        end
    end

    // Fill monitor: every fill_we must match the oldest expected fill
    initial begin
        fill_t e;
        forever begin
            @(negedge clock);
            if (fill_we === 1'b1) begin
                fill_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_fill: fill_we got 1, expected 0");
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("fill_index", 256'(fill_index), 256'(e.idx));
                    checkOutput("fill_tag", 256'(fill_tag), 256'(e.tag));
                    checkOutput("fill_data", fill_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset     = 1'b0;
        miss_req  = 1'b0;
        miss_addr = 32'd0;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_busy", 256'(busy), 256'd0);
        checkOutput("rst_mem_req", 256'(mem_req), 256'd0);
        checkOutput("rst_mem_addr", 256'(mem_addr), 256'd0);
        checkOutput("rst_fill_we", 256'(fill_we), 256'd0);
        checkOutput("rst_fill_index", 256'(fill_index), 256'd0);
        checkOutput("rst_fill_tag", 256'(fill_tag), 256'd0);
        checkOutput("rst_fill_data", fill_data, 256'd0);
        checkOutput("rst_miss_count", 256'(miss_count), 256'd0);
        reset = 1'b1;

        // Spurious mem_ack in IDLE
        $display("[TB] spurious ack in IDLE");
        ack_mode = 3;
        repeat (4) begin
            @(negedge clock);
            checkOutput("spur_busy", 256'(busy), 256'd0);
            checkOutput("spur_mem_req", 256'(mem_req), 256'd0);
        end
        ack_mode = 0;
        @(negedge clock);

        // Single miss, zero wait states
        $display("[TB] single miss at 0x124");
        ack_mode  = 1;
        data_base = 32'h0000_1000;
        addr_log.delete();
        exp_q.push_back('{idx: 4'd9, tag: 23'd0, data: make_line(32'h0000_1000)});
        applyStimulus(32'h0000_0124, cycles);
        checkOutput("t1_cycles", 256'(cycles), 256'd11);
        checkAddrLog(32'h0000_0120);
        checkOutput("t1_miss_count", 256'(miss_count), 256'd1);
        checkOutput("t1_fills", 256'(fill_seen), 256'd1);

        // Ack every third cycle
        $display("[TB] miss at 0x1A60 with wait states");
        ack_mode  = 2;
        data_base = 32'h0000_2000;
        addr_log.delete();
        exp_q.push_back('{idx: 4'd3, tag: 23'd13, data: make_line(32'h0000_2000)});
        applyStimulus(32'h0000_1A60, cycles);
        checkOutput("t2_cycles", 256'(cycles), 256'd27);
        checkAddrLog(32'h0000_1A60);
        checkOutput("t2_miss_count", 256'(miss_count), 256'd2);

        // Reset while word 4 is being requested
        $display("[TB] reset during word 4");
        ack_mode = 1;
        @(negedge clock);
        miss_req  = 1'b1;
        miss_addr = 32'h0000_0300;
        repeat (5) @(posedge clock);
        @(negedge clock);
        miss_req = 1'b0;
        checkOutput("t3_mem_addr_w4", 256'(mem_addr), 256'h310);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("t3_busy", 256'(busy), 256'd0);
        checkOutput("t3_mem_req", 256'(mem_req), 256'd0);
        checkOutput("t3_fill_we", 256'(fill_we), 256'd0);
        checkOutput("t3_miss_count", 256'(miss_count), 256'd0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("t3_idle_after", 256'(busy), 256'd0);

        // miss_addr changed mid-refill, miss_req held through DONE, back-to-back miss
        $display("[TB] held miss_req and back-to-back miss");
        data_base = 32'h0000_3000;
        exp_q.push_back('{idx: 4'd2, tag: 23'd0, data: make_line(32'h0000_3000)});
        exp_q.push_back('{idx: 4'd0, tag: 23'd1, data: make_line(32'h0000_4000)});
        @(negedge clock);
        miss_req  = 1'b1;
        miss_addr = 32'h0000_0040;
        @(posedge clock);
        repeat (3) @(negedge clock);
        miss_addr = 32'hFFFF_FFE0;
        n = 0;
        while (fill_we !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput("t4_fill_reached", 256'(fill_we), 256'd1);
        data_base = 32'h0000_4000;
        @(negedge clock);
        miss_addr = 32'h0000_0200;
        checkOutput("t4_done_busy", 256'(busy), 256'd1);
        checkOutput("t4_done_mem_req", 256'(mem_req), 256'd0);
        @(negedge clock);
        checkOutput("t4_no_refill_from_done", 256'(busy), 256'd0);
        checkOutput("t4_idle_mem_req", 256'(mem_req), 256'd0);
        @(negedge clock);
        miss_req = 1'b0;
        checkOutput("t5_new_busy", 256'(busy), 256'd1);
        checkOutput("t5_new_mem_addr", 256'(mem_addr), 256'h200);
        checkOutput("t5_miss_count", 256'(miss_count), 256'd2);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        checkOutput("t5_back_to_idle", 256'(busy), 256'd0);

        repeat (2) @(negedge clock);
        checkOutput("pending_fills", 256'(exp_q.size()), 256'd0);
        checkOutput("total_fills", 256'(fill_seen), 256'd4);
        checkOutput("final_miss_count", 256'(miss_count), 256'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
